whac_game_engine: RTL and testbench

WHAC_GAME_ENGINE -- requirements
Module: whac_game_engine

---
 rtl/whac_game_engine.sv | 199 +++++++++++++++++++
 tb/tb_whac_game_engine.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/whac_game_engine.sv
// rtl/whac_game_engine.sv - whack-a-mole engine: ms timebase, LFSR mole placement, combo/score keeping
module whac_game_engine #(
    parameter int          NUM_HOLES        = 18,
    parameter int          CLKS_PER_MS      = 50000,
    parameter int          GAME_MS          = 20000,
    parameter int          UP_MS            = 1000,
    parameter int          DOWN_MS          = 1000,
    parameter int          MAX_COMBO        = 99,
    parameter int          MAX_SCORE        = 9999,
    parameter int          FULL_CLEAR_BONUS = 10,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [1:0]                       difficulty,
    input  logic [NUM_HOLES-1:0]             hit_mask,
    output logic [NUM_HOLES-1:0]             mole_mask,
    output logic                             game_in_progress,
    output logic [$clog2(GAME_MS+1)-1:0]     time_left_ms,
    output logic [$clog2(MAX_COMBO+1)-1:0]   combo,
    output logic [$clog2(MAX_SCORE+1)-1:0]   score,
    output logic [$clog2(MAX_SCORE+1)-1:0]   high_score,
    output logic                             game_over
);
    localparam int TW    = $clog2(GAME_MS+1);
    localparam int CW    = $clog2(MAX_COMBO+1);
    localparam int SW    = $clog2(MAX_SCORE+1);
    localparam int PW    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int MAXPH = (UP_MS > DOWN_MS) ? ((UP_MS > 1) ? UP_MS : 1) : ((DOWN_MS > 1) ? DOWN_MS : 1);
    localparam int PHW   = $clog2(MAXPH+1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DOWN = 2'd1;
    localparam logic [1:0] S_UP   = 2'd2;
    localparam logic [1:0] S_OVER = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [1:0]           diff_q, diff_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [PHW-1:0]       phase_q, phase_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [NUM_HOLES-1:0] mask_q, mask_d;
    logic [TW-1:0]        time_q, time_d;
    logic [CW-1:0]        combo_q, combo_d;
    logic [SW-1:0]        score_q, score_d;
    logic [SW-1:0]        high_q, high_d;

    logic                 running, tick, phase_last, time_end;
    logic [PHW-1:0]       up_len, down_len, cur_len;
    logic [31:0]          i0, i1;
    logic [NUM_HOLES-1:0] new_mask, hits, misses, rem;
    logic [5:0]           k;
    logic [31:0]          combo_sum, score_sum, score_bonus;

    assign running    = (state_q == S_DOWN) || (state_q == S_UP);
    assign tick       = running && (presc_q == PW'(CLKS_PER_MS-1));
    assign time_end   = tick && (time_q == TW'(1));
    assign lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // Phase lengths halve per difficulty level but never drop below one ms.
    always_comb begin
        up_len   = PHW'(UP_MS) >> diff_q;
        down_len = PHW'(DOWN_MS) >> diff_q;
        if (up_len == '0)   up_len = PHW'(1);
        if (down_len == '0) down_len = PHW'(1);
        cur_len    = (state_q == S_UP) ? up_len : down_len;
        phase_last = (phase_q == cur_len - PHW'(1));
    end

    // Second hole is offset by 1..NUM_HOLES-1 from the first, so it is always distinct.
    always_comb begin
        i0 = {16'h0000, lfsr_q} % NUM_HOLES;
        i1 = (i0 + 32'd1 + ({24'h000000, lfsr_q[15:8]} % (NUM_HOLES-1))) % NUM_HOLES;
        new_mask = {{(NUM_HOLES-1){1'b0}}, 1'b1} << i0;
        if (diff_q >= 2'd2) new_mask = new_mask | ({{(NUM_HOLES-1){1'b0}}, 1'b1} << i1);
    end

    always_comb begin
        hits   = hit_mask & mask_q;
        misses = hit_mask & ~mask_q;
        rem    = mask_q & ~hit_mask;
        k      = '0;
        for (int b = 0; b < NUM_HOLES; b++) k = k + {5'b00000, hits[b]};
        combo_sum   = {{(32-CW){1'b0}}, combo_q} + {26'h0, k};
        if (combo_sum > MAX_COMBO) combo_sum = MAX_COMBO;
        score_sum   = {{(32-SW){1'b0}}, score_q} + combo_sum;
        if (score_sum > MAX_SCORE) score_sum = MAX_SCORE;
        score_bonus = score_sum;
        if (rem == '0) score_bonus = score_sum + FULL_CLEAR_BONUS;
        if (score_bonus > MAX_SCORE) score_bonus = MAX_SCORE;
    end

    always_comb begin
        state_d = state_q;
        diff_d  = diff_q;
        presc_d = presc_q;
        phase_d = phase_q;
        mask_d  = mask_q;
        time_d  = time_q;
        combo_d = combo_q;
        score_d = score_q;
        high_d  = high_q;

        if (running) presc_d = tick ? '0 : presc_q + PW'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DOWN;
                    diff_d  = difficulty;
                    presc_d = '0;
                    phase_d = '0;
                    mask_d  = '0;
                    time_d  = TW'(GAME_MS);
                    combo_d = '0;
                    score_d = '0;
                end
            end
            S_DOWN: begin
                if (|hit_mask) combo_d = '0;
                if (tick) begin
                    if (phase_last) begin
                        state_d = S_UP;
                        mask_d  = new_mask;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PHW'(1);
                    end
                end
            end
            S_UP: begin
                mask_d = rem;
                if (|misses) begin
                    combo_d = '0;
                end else if (|hits) begin
                    combo_d = combo_sum[CW-1:0];
                    score_d = score_bonus[SW-1:0];
                end
                if (tick && phase_last) begin
                    // Game end overrides the phase transition, including its timeout miss.
                    if ((|rem) && !time_end) combo_d = '0;
                    mask_d  = '0;
                    state_d = S_DOWN;
                    phase_d = '0;
                end else if (rem == '0) begin
                    state_d = S_DOWN;
                    phase_d = '0;
                end else if (tick) begin
                    phase_d = phase_q + PHW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                if (score_q > high_q) high_d = score_q;
            end
        endcase

        if (tick) time_d = time_q - TW'(1);
        if (time_end) begin
            state_d = S_OVER;
            mask_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            diff_q  <= '0;
            presc_q <= '0;
            phase_q <= '0;
            lfsr_q  <= LFSR_SEED;
            mask_q  <= '0;
            time_q  <= '0;
            combo_q <= '0;
            score_q <= '0;
            high_q  <= '0;
        end else begin
            state_q <= state_d;
            diff_q  <= diff_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
            lfsr_q  <= lfsr_d;
            mask_q  <= mask_d;
            time_q  <= time_d;
            combo_q <= combo_d;
            score_q <= score_d;
            high_q  <= high_d;
        end
    end

    assign mole_mask        = mask_q;
    assign game_in_progress = running;
    assign time_left_ms     = time_q;
    assign combo            = combo_q;
    assign score            = score_q;
    assign high_score       = high_q;
    assign game_over        = (state_q == S_OVER);
endmodule

// File: tb/tb_whac_game_engine.sv
// tb/tb_whac_game_engine.sv - directed bench for whac_game_engine with a reference mole-placement LFSR
module tb_whac_game_engine;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [1:0]  difficulty;
    logic [3:0]  hit_mask;
    logic [3:0]  mole_mask;
    logic        game_in_progress;
    logic [4:0]  time_left_ms;
    logic [6:0]  combo;
    logic [13:0] score, high_score;
    logic        game_over;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] ref_lfsr;

    always #5 clk = ~clk;

    whac_game_engine #(
        .NUM_HOLES(4), .CLKS_PER_MS(2), .GAME_MS(20), .UP_MS(4), .DOWN_MS(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .difficulty(difficulty), .hit_mask(hit_mask),
        .mole_mask(mole_mask), .game_in_progress(game_in_progress), .time_left_ms(time_left_ms),
        .combo(combo), .score(score), .high_score(high_score), .game_over(game_over)
    );

    always @(posedge clk) begin
        if (rst) ref_lfsr <= 16'hACE1;
        else     ref_lfsr <= {1'b0, ref_lfsr[15:1]} ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_mask(input logic [15:0] l, input logic [1:0] d);
        int a, b;
        logic [3:0] m;
        a = int'(l) % 4;
        b = (a + 1 + (int'(l[15:8]) % 3)) % 4;
        m = 4'b0001 << a;
        if (d >= 2'd2) m = m | (4'b0001 << b);
        return m;
    endfunction

    task automatic do_start(input logic [1:0] d);
        start = 1'b1;
        difficulty = d;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_running", game_in_progress, 1);
        check_eq("start_time", time_left_ms, 20);
        check_eq("start_score", score, 0);
    endtask

    task automatic wait_mole(output logic [3:0] m, output logic [15:0] prev, output int cyc);
        cyc = 0;
        prev = ref_lfsr;
        for (int i = 0; i < 200; i++) begin
            prev = ref_lfsr;
            @(negedge clk);
            cyc++;
            if (mole_mask != 4'b0000) break;
        end
        m = mole_mask;
        check_eq("mole_seen", {31'b0, (mole_mask != 4'b0000)}, 1);
    endtask

    task automatic whack(input logic [3:0] m);
        hit_mask = m;
        @(negedge clk);
        hit_mask = 4'b0000;
    endtask

    task automatic wait_over(input int exp_high);
        int seen, pulses;
        seen = 0;
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (game_over) begin
                seen = 1;
                break;
            end
        end
        check_eq("over_seen", seen, 1);
        check_eq("over_mask", mole_mask, 0);
        @(negedge clk);
        check_eq("over_idle", game_in_progress, 0);
        check_eq("high_score", high_score, exp_high);
        for (int i = 0; i < 10; i++) begin
            if (game_over) pulses++;
            @(negedge clk);
        end
        check_eq("over_single", pulses, 0);
    endtask

    initial begin
        logic [3:0]  m;
        logic [15:0] prev;
        int          cyc;
        int          exp_score[3] = '{11, 23, 36};

        rst = 1'b1; start = 1'b1; difficulty = 2'd0; hit_mask = 4'b0000;
        repeat (3) @(negedge clk);
        check_eq("rst_running", game_in_progress, 0);
        check_eq("rst_mask", mole_mask, 0);
        check_eq("rst_time", time_left_ms, 0);
        check_eq("rst_combo", combo, 0);
        check_eq("rst_score", score, 0);
        check_eq("rst_high", high_score, 0);
        check_eq("rst_over", game_over, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        // Game A, difficulty 0: three clean single-mole rounds.
        do_start(2'd0);
        for (int r = 1; r <= 3; r++) begin
            wait_mole(m, prev, cyc);
            if (r == 1) begin
                check_eq("first_mole_clk", cyc, 8);
                check_eq("first_mole_time", time_left_ms, 16);
            end
            check_eq("mole_d0", m, exp_mask(prev, 2'd0));
            whack(m);
            check_eq("hit_combo", combo, r);
            check_eq("hit_score", score, exp_score[r-1]);
            check_eq("hit_cleared", mole_mask, 0);
            if (r == 1) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check_eq("start_ignored_time", time_left_ms, 15);
                check_eq("start_ignored_run", game_in_progress, 1);
            end
        end
        wait_over(36);
        check_eq("score_hold", score, 36);

        // Game B, difficulty 1: empty-hole miss, rebuild combo, then let a mole time out.
        do_start(2'd1);
        for (int r = 1; r <= 3; r++) begin
            wait_mole(m, prev, cyc);
            whack(m);
            check_eq("b_combo", combo, r);
            check_eq("b_score", score, exp_score[r-1]);
        end
        wait_mole(m, prev, cyc);
        whack(~m & (m[0] ? 4'b0010 : 4'b0001));
        check_eq("miss_combo", combo, 0);
        check_eq("miss_score", score, 36);
        check_eq("miss_mole_kept", mole_mask, m);
        whack(m);
        check_eq("rehit_combo", combo, 1);
        check_eq("rehit_score", score, 47);
        wait_mole(m, prev, cyc);
        whack(m);
        check_eq("c2_combo", combo, 2);
        check_eq("c2_score", score, 59);
        wait_mole(m, prev, cyc);
        cyc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mole_mask == 4'b0000) begin
                cyc = 1;
                break;
            end
        end
        check_eq("expire_seen", cyc, 1);
        check_eq("expire_combo", combo, 0);
        check_eq("expire_running", game_in_progress, 1);
        check_eq("expire_score", score, 59);
        wait_over(59);

        // Game C, difficulty 2: two distinct moles hit together, then reset mid-game.
        do_start(2'd2);
        wait_mole(m, prev, cyc);
        check_eq("d2_mole_clk", cyc, 2);
        check_eq("d2_two_moles", $countones(m), 2);
        check_eq("d2_mole", m, exp_mask(prev, 2'd2));
        whack(m);
        check_eq("d2_combo", combo, 2);
        check_eq("d2_score", score, 12);
        check_eq("d2_cleared", mole_mask, 0);
        check_eq("d2_running", game_in_progress, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_running", game_in_progress, 0);
        check_eq("mid_rst_time", time_left_ms, 0);
        check_eq("mid_rst_combo", combo, 0);
        check_eq("mid_rst_score", score, 0);
        check_eq("mid_rst_high", high_score, 0);
        check_eq("mid_rst_mask", mole_mask, 0);
        check_eq("mid_rst_over", game_over, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, tests run %0d", n_tests);
        $fatal(1);
    end
endmodule
